// File: rtl/sram_dp_param_if.sv
// Bus bundle for sram_dp_param: read/write port 0, read-only port 1, clear-busy flag.
interface sram_dp_param_if #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WMASK_WIDTH = 4
);
    logic                   init_busy;
    logic                   csb0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic [DATA_WIDTH-1:0]  dout0;
    logic                   dout0_valid;
    logic                   csb1;
    logic [ADDR_WIDTH-1:0]  addr1;
    logic [DATA_WIDTH-1:0]  dout1;
    logic                   dout1_valid;

    modport master (
        input  init_busy, dout0, dout0_valid, dout1, dout1_valid,
        output csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

    modport slave (
        output init_busy, dout0, dout0_valid, dout1, dout1_valid,
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1
    );
endinterface

// File: rtl/sram_dp_param.sv
// Parametrised dual-port SRAM: port 0 read/write with lane mask, port 1 read-only,
// configurable read latency, read-during-write mode and optional clear sweep after reset.
module sram_dp_param #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WMASK_WIDTH    = 4,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           rst,
    sram_dp_param_if.slave bus
);
    localparam int unsigned LANE_W = DATA_WIDTH / WMASK_WIDTH;
    localparam int unsigned NSTG   = READ_LATENCY + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} clr_state_e;

    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  in0;
    logic                  in1;
    logic                  wr0;
    logic                  clr_we;
    logic [1:0]            rd_vld_d;
    logic [DATA_WIDTH-1:0] rd_word_d [2];
    logic [NSTG-1:0]       vld_q [2];
    logic [DATA_WIDTH-1:0] data_q [2][NSTG];

    if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_partial
        assign in0 = (bus.addr0 <= LAST_ADDR);
        assign in1 = (bus.addr1 <= LAST_ADDR);
    end else begin : g_full
        assign in0 = 1'b1;
        assign in1 = 1'b1;
    end

    assign wr0         = !busy_q && !bus.csb0 && !bus.web0 && in0;
    assign clr_we      = (state_q == CLEAR) && !rst;
    assign rd_vld_d[0] = !busy_q && !bus.csb0 && bus.web0;
    assign rd_vld_d[1] = !busy_q && !bus.csb1;

    always_comb begin
        rd_word_d[0] = in0 ? mem_q[bus.addr0] : '0;
        rd_word_d[1] = in1 ? mem_q[bus.addr1] : '0;
        if (RDW_MODE == 1 && wr0 && bus.addr0 == bus.addr1) begin
            for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
                if (bus.wmask0[i])
                    rd_word_d[1][i*LANE_W +: LANE_W] = bus.din0[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr_q] <= '0;
        end else if (wr0) begin
            for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
                if (bus.wmask0[i])
                    mem_q[bus.addr0][i*LANE_W +: LANE_W] <= bus.din0[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_addr_q <= '0;
            busy_q     <= (CLEAR_ON_RESET != 0);
        end else if (state_q == CLEAR) begin
            if (clr_addr_q == LAST_ADDR) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
            clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
        end
    end

    // Stage 0 snapshots the word at the command edge (pre-write); the last stage
    // doubles as the output register and only loads on a valid result so dout holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < 2; p++) begin
                vld_q[p] <= '0;
                for (int unsigned s = 0; s < NSTG; s++) data_q[p][s] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                vld_q[p][0] <= rd_vld_d[p];
                if (rd_vld_d[p]) data_q[p][0] <= rd_word_d[p];
                for (int unsigned s = 1; s < NSTG; s++) begin
                    vld_q[p][s] <= vld_q[p][s-1];
                    if (vld_q[p][s-1]) data_q[p][s] <= data_q[p][s-1];
                end
            end
        end
    end

    assign bus.init_busy   = busy_q;
    assign bus.dout0       = data_q[0][READ_LATENCY];
    assign bus.dout0_valid = vld_q[0][READ_LATENCY];
    assign bus.dout1       = data_q[1][READ_LATENCY];
    assign bus.dout1_valid = vld_q[1][READ_LATENCY];
endmodule
